// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside the ID stage: tracks in-flight destinations in a
// DEPTH-slot shift register and produces forward selects or an ID stall.
module hazard_scoreboard #(
    parameter int REG_W     = 4,
    parameter int DEPTH     = 3,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 1,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_used,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_used,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_is_load,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel1,
    output logic [SEL_W-1:0] fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    // With a write-before-read regfile the oldest slot is already visible in ID.
    localparam int LAST = (RF_BYPASS != 0) ? DEPTH - 2 : DEPTH - 1;

    typedef struct packed {
        logic             v;
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } slot_t;

    slot_t [DEPTH-1:0] slots;
    slot_t             new_entry;
    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic              load_use;
    logic              issue;

    // Lowest hit index is the youngest producer; encoded as index+1 so 0 means regfile.
    function automatic logic [SEL_W-1:0] youngest(input logic [DEPTH-1:0] h);
        youngest = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (h[i]) youngest = SEL_W'(i + 1);
        end
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i <= LAST; i++) begin
            hit1[i] = id_valid & id_src1_used & slots[i].v & slots[i].wb_en
                      & (slots[i].dest == id_src1);
            hit2[i] = id_valid & id_src2_used & slots[i].v & slots[i].wb_en
                      & (slots[i].dest == id_src2);
        end
    end

    always_comb begin
        load_use = slots[0].is_load & (hit1[0] | hit2[0]);
        stall    = 1'b0;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if (FWD_EN != 0) begin
            stall    = load_use;
            fwd_sel1 = youngest(hit1);
            fwd_sel2 = youngest(hit2);
        end else begin
            stall = |{hit1, hit2};
        end
    end

    always_comb begin
        issue             = id_valid & ~stall & ~flush & ~hold;
        new_entry         = '0;
        new_entry.v       = 1'b1;
        new_entry.wb_en   = id_wb_en;
        new_entry.dest    = id_dest;
        new_entry.is_load = id_is_load;
    end

    // NOTE: sequential state uses non-blocking assignments so every slot shifts from its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot array is tiny control state and must be cleared, unlike a datapath RAM.
            slots     <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slots[i] <= slots[i-1];
            end
            slots[0] <= issue ? new_entry : '0;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: default build (A) and a stall-only, no-bypass, 4-bit-counter build (B)
// share one stimulus stream; expectations come from an age-based model of in-flight writes.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic       id_src1_used = 1'b0, id_src2_used = 1'b0, id_wb_en = 1'b0, id_is_load = 1'b0;

    logic        stall_a, stall_b;
    logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_is_load(id_is_load), .stall(stall_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a),
        .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.FWD_EN(0), .RF_BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used), .id_src2(id_src2),
        .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .id_is_load(id_is_load), .stall(stall_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b),
        .stall_cnt(cnt_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Model: each issued write is remembered with the advance count at which it entered
    // the pipe; its age (slot) is simply how many advances have happened since.
    typedef struct {
        int       inst;
        int       tag;
        bit       wb;
        bit [3:0] dest;
        bit       ld;
    } ent_t;

    typedef struct {
        bit       st_a, st_b;
        bit [1:0] s1_a, s2_a, s1_b, s2_b;
        int       c_a, c_b;
    } exp_t;

    ent_t hist[$];
    exp_t exp_q[$];
    int   adv[2]    = '{0, 0};
    int   cnt_m[2]  = '{0, 0};
    bit   st_m[2]   = '{0, 0};
    int   cnt_max[2] = '{65535, 15};

    function automatic void predict(input int k, output bit st, output bit [1:0] s1,
                                    output bit [1:0] s2);
        bit fwd  = (k == 0);
        int last = (k == 0) ? 1 : 2;
        int age1 = 99, age2 = 99;
        bit lu = 0, any = 0;
        foreach (hist[j]) begin
            int age;
            age = adv[k] - hist[j].tag;
            if (hist[j].inst == k && hist[j].wb && age <= last) begin
                if (id_valid && id_src1_used && hist[j].dest == id_src1) begin
                    any = 1;
                    if (age < age1) age1 = age;
                    if (age == 0 && hist[j].ld) lu = 1;
                end
                if (id_valid && id_src2_used && hist[j].dest == id_src2) begin
                    any = 1;
                    if (age < age2) age2 = age;
                    if (age == 0 && hist[j].ld) lu = 1;
                end
            end
        end
        st = fwd ? lu : any;
        s1 = (fwd && age1 != 99) ? 2'(age1 + 1) : 2'd0;
        s2 = (fwd && age2 != 99) ? 2'(age2 + 1) : 2'd0;
    endfunction

    // Applies the clock edge to the model using the inputs that were present at that edge.
    function automatic void advance(input int k);
        if (rst) begin
            for (int j = hist.size() - 1; j >= 0; j--)
                if (hist[j].inst == k) hist.delete(j);
            cnt_m[k] = 0;
        end else if (!hold) begin
            if (st_m[k] && cnt_m[k] < cnt_max[k]) cnt_m[k]++;
            adv[k]++;
            if (id_valid && !st_m[k] && !flush)
                hist.push_back('{k, adv[k], id_wb_en, id_dest, id_is_load});
        end
        for (int j = hist.size() - 1; j >= 0; j--)
            if (hist[j].inst == k && adv[k] - hist[j].tag > 2) hist.delete(j);
    endfunction

    task automatic step(input bit rs, input bit hd, input bit fl, input bit v,
                        input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2,
                        input bit wb, input bit [3:0] d, input bit ld);
        exp_t e;
        @(posedge clk);
        advance(0);
        advance(1);
        #1;
        rst = rs; hold = hd; flush = fl; id_valid = v;
        id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_wb_en = wb; id_dest = d; id_is_load = ld;
        predict(0, e.st_a, e.s1_a, e.s2_a);
        predict(1, e.st_b, e.s1_b, e.s2_b);
        st_m[0] = e.st_a;
        st_m[1] = e.st_b;
        e.c_a = cnt_m[0];
        e.c_b = cnt_m[1];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever expectation is pending once outputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_a", stall_a, e.st_a);
                if (!e.st_a) begin
                    check("fwd_sel1_a", sel1_a, e.s1_a);
                    check("fwd_sel2_a", sel2_a, e.s2_a);
                end
                check("stall_cnt_a", cnt_a, e.c_a);
                check("stall_b", stall_b, e.st_b);
                check("fwd_sel1_b", sel1_b, e.s1_b);
                check("fwd_sel2_b", sel2_b, e.s2_b);
                check("stall_cnt_b", cnt_b, e.c_b);
            end
        end
    end

    initial begin
        int waited;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ADD r1; ADD r2,r1; then another reader of r1 one cycle later
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0, 1, 2, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0, 1, 6, 0);
        idle(3);
        // LDR r3 then a user of r3 held in ID until it issues
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 1, 0, 0, 1, 7, 0);
        idle(3);
        // two writers of r4, then reader on src2
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 4, 1, 0, 0, 0);
        idle(3);
        // flushed writer of r7 must leave no hazard; same register on both sources
        step(0, 0, 1, 1, 0, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 1, 7, 1, 7, 1, 0, 0, 0);
        step(0, 0, 0, 1, 7, 1, 7, 1, 1, 8, 1);
        step(0, 0, 0, 1, 8, 1, 8, 1, 0, 0, 0);
        idle(3);
        // load-use hazard frozen by hold for three cycles
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 9, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        idle(3);
        // self-dependent chain: build B stalls long enough to saturate its counter
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 5, 1, 0, 0, 1, 5, 0);
        // reset in the middle of a load-use hazard
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 10, 1);
        step(0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 10, 1, 10, 1, 0, 0, 0);
        idle(2);
        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0);
        end
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
